// File: rtl/nukv_request_arbiter.sv
// nukv_request_arbiter: packet-granular round-robin merge of NUM_PORTS request streams into one tagged stream
module nukv_request_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BEATS  = 512
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic [1:0]                      m_axis_tuser,
  input  logic                            m_axis_tready,
  input  logic [NUM_PORTS-1:0]            port_enable,
  input  logic                            hold_new,
  output logic [3:0]                      _debug
);
  typedef enum logic {ST_IDLE, ST_STREAM} state_t;
  state_t                  state_q;
  logic [1:0]              grant_q, grant_d, last_grant_q, err_q, idx;
  logic [15:0]             beat_cnt_q, beat_cnt_d;
  logic [3:0]              req4, vld4, last4;
  logic                    found, ready, accept;
  logic [DATA_WIDTH-1:0]   sel_data;

  // Round-robin pick: scan from last_grant+1 upward; the closest requester wins
  always_comb begin
    req4    = 4'(s_axis_tvalid & port_enable);
    grant_d = grant_q;
    found   = 1'b0;
    idx     = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = 2'((int'(last_grant_q) + i) % NUM_PORTS);
      if (req4[idx]) begin
        found   = 1'b1;
        grant_d = idx;
      end
    end
  end

  // Only the granted port sees ready, and only while the output register can take a beat
  always_comb begin
    vld4          = 4'(s_axis_tvalid);
    last4         = 4'(s_axis_tlast);
    ready         = (state_q == ST_STREAM) && (!m_axis_tvalid || m_axis_tready);
    accept        = ready && vld4[grant_q];
    s_axis_tready = NUM_PORTS'(ready ? 4'b0001 << grant_q : 4'b0000);
    sel_data      = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant_q == 2'(i)) sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    beat_cnt_d    = accept && last4[grant_q] ? 16'd0 :
                    accept && beat_cnt_q != 16'hffff ? beat_cnt_q + 16'd1 : beat_cnt_q;
  end

  assign _debug = {grant_q, err_q};

  // Arbitration FSM with registered output stage; a packet is never cut short by hold_new or port_enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_grant_q  <= 2'(NUM_PORTS - 1);
      beat_cnt_q    <= '0;
      err_q         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      if (accept) begin
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= last4[grant_q];
        m_axis_tuser  <= grant_q;
        m_axis_tvalid <= 1'b1;
        if (int'(beat_cnt_q) >= MAX_BEATS) err_q <= 2'd2;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (state_q == ST_IDLE && !hold_new && found) begin
        grant_q <= grant_d;
        state_q <= ST_STREAM;
      end
      if (accept && last4[grant_q]) begin
        last_grant_q <= grant_q;
        state_q      <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_nukv_request_arbiter.sv
// tb_nukv_request_arbiter: randomized packet traffic scored against a packet-level round-robin model
module tb_nukv_request_arbiter;
  localparam int NP = 2, DW = 128, MB = 8;
  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NP*DW-1:0]  s_axis_tdata = '0;
  logic [NP-1:0]     s_axis_tvalid = '0, s_axis_tlast = '0, port_enable = '1;
  logic [NP-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tlast;
  logic [1:0]        m_axis_tuser;
  logic              m_axis_tready = 1'b1, hold_new = 1'b0;
  logic [3:0]        dbg;

  typedef struct packed {logic [DW-1:0] d; logic l; logic [1:0] p;} exp_t;
  exp_t        exp_q[$];
  logic [DW+1:0] mem [NP][256];
  int          nb[NP], npk[NP], plen[NP][64], rd[NP];
  int          checks = 0, errors = 0, cyc = 0, start_cyc = 0, phase_id = 0, r0_hits = 0;
  bit          active = 0, started = 0, strict = 0, gaps = 0, rand_ready = 0, rand_hold = 0, err_exp = 0;

  nukv_request_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .port_enable(port_enable), .hold_new(hold_new), ._debug(dbg)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic add_pkt(input int p, input int len);
    for (int b = 0; b < len; b++) mem[p][nb[p]+b] = {b == 0, b == len - 1, rnd()};
    nb[p] += len;
    plen[p][npk[p]] = len;
    npk[p]++;
  endtask

  // Model: whole packets in round-robin order among enabled ports that still have packets
  task automatic build_exp(input logic [NP-1:0] en);
    int last, q;
    int pk[NP], ofs[NP];
    bit f;
    exp_t e;
    last = NP - 1;
    err_exp = 0;
    for (int p = 0; p < NP; p++) begin
      pk[p] = 0;
      ofs[p] = 0;
    end
    do begin
      f = 0;
      for (int i = 1; i <= NP && !f; i++) begin
        q = (last + i) % NP;
        if (en[q] && pk[q] < npk[q]) begin
          for (int b = 0; b < plen[q][pk[q]]; b++) begin
            e.d = mem[q][ofs[q]+b][DW-1:0];
            e.l = (b == plen[q][pk[q]] - 1);
            e.p = 2'(q);
            exp_q.push_back(e);
          end
          if (plen[q][pk[q]] > MB) err_exp = 1;
          ofs[q] += plen[q][pk[q]];
          pk[q]++;
          last = q;
          f = 1;
        end
      end
    end while (f);
  endtask

  // Source driver: each port presents its beats in order; first beats are never delayed
  initial begin
    logic [NP-1:0] hs, v;
    v = '0;
    forever begin
      @(negedge clk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (!active) begin
          v[p] = 1'b0;
          rd[p] = 0;
        end else begin
          if (hs[p]) rd[p]++;
          if (rd[p] >= nb[p]) v[p] = 1'b0;
          else begin
            if (!(v[p] && !hs[p])) v[p] = mem[p][rd[p]][DW+1] || !gaps || $urandom_range(0, 2) != 0;
            s_axis_tdata[p*DW +: DW] = mem[p][rd[p]][DW-1:0];
            s_axis_tlast[p] = mem[p][rd[p]][DW];
          end
        end
      end
      if (!active) started = 0;
      else if (v != '0 && !started) begin
        started = 1;
        start_cyc = cyc;
      end
      s_axis_tvalid = v;
      if (rand_ready) m_axis_tready = $urandom_range(0, 1) == 1;
      if (rand_hold) hold_new = $urandom_range(0, 3) == 0;
    end
  end

  // Monitor: pop the scoreboard on every output handshake
  initial begin
    exp_t e;
    int mon_phase, prev_cyc;
    bit have_prev, prev_last;
    mon_phase = 0;
    have_prev = 0;
    prev_cyc = 0;
    prev_last = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready[0]) r0_hits++;
      if (mon_phase != phase_id) begin
        mon_phase = phase_id;
        have_prev = 0;
      end
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, e.d);
          chk("tlast", m_axis_tlast, e.l);
          chk("tuser", m_axis_tuser, e.p);
          if (strict) chk("timing", cyc - (have_prev ? prev_cyc : start_cyc), (have_prev && !prev_last) ? 1 : 2);
          have_prev = 1;
          prev_cyc = cyc;
          prev_last = e.l;
        end
      end
    end
  end

  task automatic do_reset();
    active = 0;
    rand_ready = 0;
    rand_hold = 0;
    strict = 0;
    gaps = 0;
    hold_new = 0;
    m_axis_tready = 1;
    port_enable = '1;
    @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    nb = '{default: 0};
    npk = '{default: 0};
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_debug", dbg, 0);
    chk("rst_sready", s_axis_tready, 0);
    rst_n = 1;
  endtask

  task automatic start(input logic [NP-1:0] en, input bit st, input bit gp, input bit rr, input bit rh);
    port_enable = en;
    strict = st;
    gaps = gp;
    rand_ready = rr;
    rand_hold = rh;
    build_exp(en);
    phase_id++;
    active = 1;
  endtask

  task automatic finish_phase(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_drain"}, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 chk({nm, "_err"}, dbg[1:0], err_exp ? 2 : 0);
  endtask

  initial begin
    int base, t;
    do_reset();
    add_pkt(0, 3);
    start(2'b11, 1, 0, 0, 0);
    finish_phase("single");

    do_reset();
    for (int k = 0; k < 2; k++) begin
      add_pkt(0, 2);
      add_pkt(1, 2);
    end
    start(2'b11, 1, 0, 0, 0);
    finish_phase("rr_alt");

    do_reset();
    for (int k = 0; k < 6; k++) begin
      add_pkt(0, $urandom_range(1, 6));
      add_pkt(1, $urandom_range(1, 6));
    end
    start(2'b11, 0, 1, 1, 1);
    finish_phase("random");

    do_reset();
    add_pkt(0, 3);
    add_pkt(1, 2);
    start(2'b11, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    repeat (3) @(posedge clk);
    #2 hold_new = 1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("hold_pending", exp_q.size(), 2);
    chk("hold_idle", m_axis_tvalid, 0);
    hold_new = 0;
    finish_phase("hold");

    do_reset();
    for (int k = 0; k < 3; k++) add_pkt(0, $urandom_range(1, 5));
    for (int k = 0; k < 4; k++) add_pkt(1, $urandom_range(1, 5));
    base = r0_hits;
    start(2'b10, 0, 1, 1, 1);
    finish_phase("en10");
    chk("en10_ready0", r0_hits - base, 0);

    do_reset();
    add_pkt(0, MB);
    add_pkt(1, MB);
    start(2'b11, 0, 1, 1, 0);
    finish_phase("maxbeats_ok");

    do_reset();
    add_pkt(1, MB + 1);
    add_pkt(0, 2);
    start(2'b11, 0, 1, 1, 0);
    finish_phase("maxbeats_over");

    do_reset();
    for (int k = 0; k < 3; k++) begin
      add_pkt(0, $urandom_range(3, 6));
      add_pkt(1, $urandom_range(3, 6));
    end
    start(2'b11, 0, 1, 1, 0);
    t = 0;
    while (!m_axis_tvalid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_seen", m_axis_tvalid, 1);
    #2 rst_n = 0;
    active = 0;
    #1;
    chk("rst_async_tvalid", m_axis_tvalid, 0);
    chk("rst_async_sready", s_axis_tready, 0);

    do_reset();
    for (int k = 0; k < 2; k++) begin
      add_pkt(0, 2);
      add_pkt(1, 2);
    end
    start(2'b11, 1, 0, 0, 0);
    finish_phase("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
